gmii_tx_framer: RTL and testbench

- Builds complete Ethernet frames on the GMII byte interface from a byte-stream payload (dest MAC onward, no FCS).
- Adds preamble/SFD, pads short frames, appends CRC-32 FCS and enforces the inter-frame gap.
- Sits directly upstream of gmii_tx_buffer and drives its gmii_tx_en/gmii_txd.
- At 10/100M it stretches the gap so the 2x-expanding downstream buffer never accumulates frames.

---
 rtl/eth_pkg.sv | 31 +++
 rtl/crc32_d8_reg.sv | 35 +++
 rtl/gmii_tx_framer.sv | 184 ++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions: FSM states, wire constants and the
// byte-wide reflected CRC-32 step used by both the tx framer and the rx checker.
package eth_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    BADFCS,
    DROP,
    IFG
  } state_t;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;

  // IEEE 802.3 CRC-32 (0x04C11DB7), reflected form, one byte LSB first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8_reg.sv
// CRC-32 register: init loads all-ones, en folds in one byte per clock.
// Output is the raw (uncomplemented) register, valid the cycle after the update.
module crc32_d8_reg
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc32_d8(crc_q, d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// Wraps a payload byte stream into a GMII frame (preamble, SFD, pad, FCS, gap).
// GMII outputs are registered (1 cycle); s_ready is high only while payload can be taken.
module gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PRE_LEN     = 7,
  parameter int MIN_PAYLOAD = 60,
  parameter int MAX_PAYLOAD = 1514,
  parameter int IFG_BYTES   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eth_10_100m_en,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       tx_err
);

  localparam logic [11:0] PRE_END = 12'(PRE_LEN - 1);
  localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);
  localparam logic [11:0] IFG_LEN = 12'(IFG_BYTES);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [11:0] wire_q, wire_d;
  logic        speed_q, speed_d;
  logic        skip_q, skip_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_err_q, tx_err_d;

  logic        crc_init, crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc;
  logic        abort;
  logic [11:0] gap_end;

  function automatic logic [7:0] crc_byte(input logic [31:0] c, input logic [1:0] i);
    return c[{i, 3'b000} +: 8];
  endfunction

  crc32_d8_reg u_crc (
    .clk  (clk),
    .rst_n(rst_n),
    .init (crc_init),
    .en   (crc_en),
    .d    (crc_din),
    .crc  (crc)
  );

  assign abort   = (state_q == DATA) && (!s_valid || byte_cnt_q == MAX_CNT);
  // At 10/100M the downstream buffer doubles every byte, so the gap must cover the frame too.
  assign gap_end = (speed_q ? (IFG_LEN + IFG_LEN + wire_q) : IFG_LEN) - 12'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (s_valid) state_d = PRE;
      PRE:     if (cnt_q == PRE_END) state_d = SFD;
      SFD:     state_d = DATA;
      DATA: begin
        if (abort) begin
          state_d = BADFCS;
        end else if (s_last) begin
          state_d = (byte_cnt_q + 11'd1 < MIN_CNT) ? PAD : FCS;
        end
      end
      PAD:     if (byte_cnt_q + 11'd1 == MIN_CNT) state_d = FCS;
      FCS:     if (cnt_q[1:0] == 2'd3) state_d = IFG;
      BADFCS:  if (cnt_q[1:0] == 2'd3) state_d = skip_q ? IFG : DROP;
      DROP:    if (s_valid && s_last) state_d = IFG;
      IFG:     if (cnt_q == gap_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    speed_d    = speed_q;
    skip_d     = skip_q;
    tx_en_d    = 1'b0;
    txd_d      = 8'h00;
    tx_err_d   = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    crc_din    = s_data;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        speed_d = eth_10_100m_en;
        skip_d  = 1'b0;
      end
      PRE: begin
        tx_en_d = 1'b1;
        txd_d   = ETH_PREAMBLE;
        cnt_d   = (cnt_q == PRE_END) ? '0 : cnt_q + 12'd1;
      end
      SFD: begin
        tx_en_d    = 1'b1;
        txd_d      = ETH_SFD;
        crc_init   = 1'b1;
        byte_cnt_d = '0;
      end
      DATA: begin
        tx_en_d = 1'b1;
        // The abort cycle already carries the first bad-FCS byte so tx_en has no hole.
        if (abort) begin
          txd_d    = crc_byte(crc, 2'd0);
          tx_err_d = 1'b1;
          cnt_d    = 12'd1;
          skip_d   = s_valid & s_last;
        end else begin
          txd_d      = s_data;
          crc_en     = 1'b1;
          byte_cnt_d = byte_cnt_q + 11'd1;
        end
      end
      PAD: begin
        tx_en_d    = 1'b1;
        crc_din    = 8'h00;
        crc_en     = 1'b1;
        byte_cnt_d = byte_cnt_q + 11'd1;
      end
      FCS: begin
        tx_en_d = 1'b1;
        txd_d   = ~crc_byte(crc, cnt_q[1:0]);
        cnt_d   = (cnt_q[1:0] == 2'd3) ? '0 : cnt_q + 12'd1;
      end
      BADFCS: begin
        tx_en_d = 1'b1;
        txd_d   = crc_byte(crc, cnt_q[1:0]);
        cnt_d   = (cnt_q[1:0] == 2'd3) ? '0 : cnt_q + 12'd1;
      end
      IFG:     cnt_d = cnt_q + 12'd1;
      default: ;
    endcase
    wire_d = (state_q == IDLE) ? '0 : wire_q + {11'd0, tx_en_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      wire_q     <= '0;
      speed_q    <= 1'b0;
      skip_q     <= 1'b0;
      tx_en_q    <= 1'b0;
      txd_q      <= 8'h00;
      tx_err_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      wire_q     <= wire_d;
      speed_q    <= speed_d;
      skip_q     <= skip_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
      tx_err_q   <= tx_err_d;
    end
  end

  assign s_ready    = (state_q == DATA) || (state_q == DROP);
  assign busy       = (state_q != IDLE) && (state_q != IFG);
  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign tx_err     = tx_err_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Random-payload bench for gmii_tx_framer: wire frames are rebuilt from the framing
// rules (preamble, pad, truncation, MSB-first CRC) and compared byte for byte.
module tb_gmii_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       eth_10_100m_en = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready, gmii_tx_en, busy, tx_err;
  logic [7:0] gmii_txd;

  logic        c_init = 1'b0, c_en = 1'b0;
  logic [7:0]  c_d = 8'h00;
  logic [31:0] c_crc;

  int vec = 0, errs = 0;
  logic [7:0] cur[$], got[$], exp_q[$], pay[$];
  int frames_done = 0, low_cnt = 0, last_low = 0, err_cnt = 0;
  bit prev_en = 1'b0;

  always #5 clk = ~clk;

  gmii_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .eth_10_100m_en(eth_10_100m_en),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd), .busy(busy), .tx_err(tx_err)
  );

  crc32_d8_reg u_crc (
    .clk(clk), .rst_n(rst_n), .init(c_init), .en(c_en), .d(c_d), .crc(c_crc)
  );

  // Wire monitor: collects each tx_en burst as a frame and the idle run before it.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cur.delete();
      prev_en = 1'b0;
      low_cnt = 0;
    end else begin
      if (gmii_tx_en) begin
        if (!prev_en) last_low = low_cnt;
        cur.push_back(gmii_txd);
        low_cnt = 0;
      end else begin
        if (prev_en) begin
          got = cur;
          cur.delete();
          frames_done++;
        end
        low_cnt++;
      end
      if (tx_err) err_cnt++;
      prev_en = gmii_tx_en;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // MSB-first CRC-32 on bits in wire order; the result is bit-reversed into register form.
  function automatic logic [31:0] model_crc(input logic [7:0] b[$]);
    logic [31:0] m, r;
    logic [7:0]  v;
    logic        fb;
    m = 32'hFFFFFFFF;
    foreach (b[i]) begin
      v = b[i];
      for (int k = 0; k < 8; k++) begin
        fb = m[31] ^ v[k];
        m  = {m[30:0], 1'b0};
        if (fb) m = m ^ 32'h04C11DB7;
      end
    end
    for (int k = 0; k < 32; k++) r[k] = m[31-k];
    return r;
  endfunction

  task automatic build_exp(input bit good);
    logic [7:0]  body[$];
    logic [31:0] c;
    int n;
    exp_q.delete();
    n = (pay.size() > 1514) ? 1514 : pay.size();
    for (int i = 0; i < n; i++) body.push_back(pay[i]);
    if (good) while (body.size() < 60) body.push_back(8'h00);
    c = model_crc(body);
    if (good) c = ~c;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic gen(input int len);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send(input int stall_after, input int stop_after);
    bit acc;
    for (int i = 0; i < pay.size(); i++) begin
      s_valid = 1'b1;
      s_data  = pay[i];
      s_last  = (i == pay.size() - 1);
      acc = 1'b0;
      for (int t = 0; t < 4000 && !acc; t++) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        vec++; errs++;
        $display("FAIL send_timeout: byte %0d not accepted, ready=%b required 1", i, s_ready);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      if (i + 1 == stop_after) begin
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      if (i + 1 == stall_after) begin
        s_valid = 1'b0; s_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    vec++;
    if (frames_done < target) begin
      errs++;
      $display("FAIL frame_timeout: frames seen %0d, required %0d", frames_done, target);
    end
  endtask

  task automatic test_reset();
    #3;
    vec++;
    if ({gmii_tx_en, gmii_txd, busy, s_ready, tx_err} !== 12'h000) begin
      errs++;
      $display("FAIL reset_outputs: got %h, required 000", {gmii_tx_en, gmii_txd, busy, s_ready, tx_err});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_crc_check();
    string s;
    logic [7:0] b[$];
    s = "123456789";
    c_init = 1'b1;
    @(posedge clk); #1;
    c_init = 1'b0;
    c_en   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      c_d = s[i];
      b.push_back(s[i]);
      @(posedge clk); #1;
    end
    c_en = 1'b0;
    vec++;
    if (~c_crc !== 32'hCBF43926) begin
      errs++;
      $display("FAIL crc_check_value: got %h, required cbf43926", ~c_crc);
    end
    vec++;
    if (c_crc !== model_crc(b)) begin
      errs++;
      $display("FAIL crc_vs_model: got %h, required %h", c_crc, model_crc(b));
    end
  endtask

  task automatic test_good_frame(input int len, input bit speed, input string name);
    int e0, base, g, nbad;
    gen(len);
    eth_10_100m_en = speed;
    e0   = err_cnt;
    base = frames_done;
    send(0, 0);
    wait_frames(base + 1);
    build_exp(1'b1);
    vec++;
    if (got.size() !== exp_q.size()) begin
      errs++;
      $display("FAIL %s_len: got %0d bytes, required %0d", name, got.size(), exp_q.size());
    end
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (got[i] !== exp_q[i]) begin
        if (nbad == 0) $display("FAIL %s_byte: byte %0d is %h, required %h", name, i, got[i], exp_q[i]);
        nbad++;
      end
    vec++;
    if (nbad != 0) errs++;
    vec++;
    if (err_cnt !== e0) begin
      errs++;
      $display("FAIL %s_tx_err: %0d pulses, required 0", name, err_cnt - e0);
    end
    g = speed ? 24 + exp_q.size() : 12;
    eth_10_100m_en = 1'b0;
    gen(5);
    send(0, 0);
    wait_frames(base + 2);
    vec++;
    if (last_low < g || last_low > g + 2) begin
      errs++;
      $display("FAIL %s_gap: %0d idle cycles, required %0d..%0d", name, last_low, g, g + 2);
    end
    build_exp(1'b1);
    vec++;
    if (got !== exp_q) begin
      errs++;
      $display("FAIL %s_follower: frame of %0d bytes differs from required %0d-byte frame", name, got.size(), exp_q.size());
    end
  endtask

  task automatic test_underrun();
    int e0, base;
    gen(40);
    e0   = err_cnt;
    base = frames_done;
    send(20, 0);
    wait_frames(base + 1);
    pay = pay[0:19];
    build_exp(1'b0);
    vec++;
    if (got !== exp_q) begin
      errs++;
      $display("FAIL underrun_frame: got %0d bytes (last %h), required %0d bytes (last %h)",
               got.size(), (got.size() > 0) ? got[got.size()-1] : 8'h00, exp_q.size(), exp_q[exp_q.size()-1]);
    end
    vec++;
    if (err_cnt - e0 !== 1) begin
      errs++;
      $display("FAIL underrun_tx_err: %0d pulses, required 1", err_cnt - e0);
    end
    gen(8);
    send(0, 0);
    wait_frames(base + 2);
    vec++;
    if (last_low < 12) begin
      errs++;
      $display("FAIL underrun_gap: %0d idle cycles, required at least 12", last_low);
    end
  endtask

  task automatic test_oversize();
    int e0, base, nbad;
    gen(1600);
    e0   = err_cnt;
    base = frames_done;
    send(0, 0);
    wait_frames(base + 1);
    build_exp(1'b0);
    vec++;
    if (got.size() !== 1526) begin
      errs++;
      $display("FAIL oversize_len: got %0d bytes, required 1526", got.size());
    end
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      if (got[i] !== exp_q[i]) begin
        if (nbad == 0) $display("FAIL oversize_byte: byte %0d is %h, required %h", i, got[i], exp_q[i]);
        nbad++;
      end
    vec++;
    if (nbad != 0) errs++;
    vec++;
    if (err_cnt - e0 !== 1) begin
      errs++;
      $display("FAIL oversize_tx_err: %0d pulses, required 1", err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_frame();
    gen(40);
    send(0, 25);
    #2;
    vec++;
    if ({gmii_tx_en, busy} !== 2'b11) begin
      errs++;
      $display("FAIL midframe_active: tx_en/busy %b, required 11", {gmii_tx_en, busy});
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({gmii_tx_en, gmii_txd, busy, s_ready, tx_err} !== 12'h000) begin
      errs++;
      $display("FAIL midframe_reset: got %h, required 000", {gmii_tx_en, gmii_txd, busy, s_ready, tx_err});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_good_frame(64, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_crc_check();
    test_good_frame(60, 1'b0, "min60");
    test_good_frame(10, 1'b0, "pad10");
    test_good_frame(100, 1'b1, "speed100");
    test_good_frame(59, 1'b0, "len59");
    test_good_frame(1514, 1'b0, "max1514");
    for (int r = 0; r < 4; r++)
      test_good_frame(int'($urandom_range(1, 200)), 1'($urandom_range(0, 1)), "rand");
    test_underrun();
    test_oversize();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
